// File: rtl/imem_req_ctrl_if.sv
// Fetch-side and instruction-memory-side signal bundle for imem_req_ctrl.
// Ports: pc/redirect/stall in from fetch; instr_in/imem_ready/timeout_err out to fetch;
//        mem_req/mem_addr out to memory; mem_ack/mem_rdata in from memory.
interface imem_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              redirect;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr_in;
  logic              imem_ready;
  logic              timeout_err;

  // master: the request controller
  modport master (
    input  pc, redirect, stall, mem_ack, mem_rdata,
    output mem_req, mem_addr, instr_in, imem_ready, timeout_err
  );

  // slave: the fetch stage plus instruction memory surrounding the controller
  modport slave (
    output pc, redirect, stall, mem_ack, mem_rdata,
    input  mem_req, mem_addr, instr_in, imem_ready, timeout_err
  );
endinterface

// File: rtl/imem_req_ctrl.sv
// Instruction-memory request controller: turns the fetch PC into req/ack reads.
// Latency: launch cycle + memory latency; a same-cycle ack gives 2 cycles per instruction.
// Backpressure: stall with a returned word parks it in a one-word buffer (HOLD) until stall drops.
// Ports: i_clk, i_rst_n (async, active-low), io_bus (imem_req_ctrl_if.master).
module imem_req_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16   // must be >= 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  imem_req_ctrl_if.master  io_bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HOLD} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_buf;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_timeout_err;
  logic              r_mem_req;

  logic              w_ready;
  logic [DATA_W-1:0] w_instr;

  // The request stays outstanding past the timeout; the error flag is only a
  // sticky diagnostic and does not abort the read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_buf         <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_mem_req     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!io_bus.redirect) begin
            r_addr     <= io_bus.pc;
            r_mem_req  <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (io_bus.mem_ack) begin
            r_mem_req <= 1'b0;
            if (!io_bus.redirect && io_bus.stall) begin
              r_buf   <= io_bus.mem_rdata;
              r_state <= S_HOLD;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (io_bus.redirect) begin
            // Read is still in flight at the memory; wait for its ack and drop it.
            r_wait_cnt <= '0;
            r_state    <= S_DRAIN;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == CNT_PRE) r_timeout_err <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (io_bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
            if (r_wait_cnt == CNT_PRE) r_timeout_err <= 1'b1;
          end
        end
        S_HOLD: begin
          // redirect drops the buffered word; ~stall means fetch consumed it
          if (io_bus.redirect || !io_bus.stall) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data path to fetch is combinational so a same-cycle ack reaches fetch
  // without an extra bubble; redirect always suppresses the word.
  always_comb begin
    w_ready = 1'b0;
    w_instr = '0;
    case (r_state)
      S_REQ: begin
        if (io_bus.mem_ack && !io_bus.redirect) begin
          w_ready = 1'b1;
          w_instr = io_bus.mem_rdata;
        end
      end
      S_HOLD: begin
        if (!io_bus.redirect) begin
          w_ready = 1'b1;
          w_instr = r_buf;
        end
      end
      default: ;
    endcase
  end

  assign io_bus.mem_req     = r_mem_req;
  assign io_bus.mem_addr    = r_addr;
  assign io_bus.imem_ready  = w_ready;
  assign io_bus.instr_in    = w_instr;
  assign io_bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_imem_req_ctrl.sv
// Directed bench for imem_req_ctrl: stimulus pushes expected words/addresses
// into queues, a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_req_ctrl;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;
  int n_ready = 0;

  logic [31:0] exp_instr[$];
  logic [31:0] exp_addr[$];

  imem_req_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_req_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Set the inputs seen by the DUT during the next clock cycle.
  task automatic drv(input logic [31:0] pc, input logic rd, input logic st,
                     input logic ak, input logic [31:0] rdat);
    @(posedge clk);
    #1;
    bus.pc        = pc;
    bus.redirect  = rd;
    bus.stall     = st;
    bus.mem_ack   = ak;
    bus.mem_rdata = rdat;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Monitor: fetch-side words and memory-side addresses.
  always @(negedge clk) begin
    if (bus.imem_ready) begin
      n_ready++;
      if (exp_instr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: instr_in=%08h with no word expected at %0t",
                 bus.instr_in, $time);
      end else begin
        chk("instr_in", bus.instr_in, exp_instr.pop_front());
      end
    end else begin
      chk("instr_zero_when_not_ready", bus.instr_in, 32'h0);
    end
    if (bus.mem_req && bus.mem_ack) begin
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack_addr: mem_addr=%08h with no address expected at %0t",
                 bus.mem_addr, $time);
      end else begin
        chk("mem_addr", bus.mem_addr, exp_addr.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h00100013;
    words[1] = 32'h00200093;
    words[2] = 32'h00300113;

    rst_n         = 1'b0;
    bus.pc        = '0;
    bus.redirect  = 1'b0;
    bus.stall     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_ready", {31'b0, bus.imem_ready}, 32'd0);
    chk("rst_timeout_err", {31'b0, bus.timeout_err}, 32'd0);

    // 1: first fetch from pc=0, ack one cycle after req
    @(posedge clk);
    #1;
    rst_n = 1'b1;                                   // IDLE cycle, launches pc=0
    exp_addr.push_back(32'h0);
    exp_instr.push_back(32'h00500093);
    drv(32'h0, 0, 0, 0, 32'h0);                     // REQ, no ack yet
    at_neg();
    chk("t1_mem_req_up", {31'b0, bus.mem_req}, 32'd1);
    drv(32'h0, 0, 0, 1, 32'h00500093);              // ack

    // 2: back-to-back pc=0,4,8 with zero-wait ack
    for (int k = 0; k < 3; k++) begin
      exp_addr.push_back(32'(4 * k));
      exp_instr.push_back(words[k]);
      drv(32'(4 * k), 0, 0, 0, 32'h0);              // IDLE launch
      drv(32'(4 * k), 0, 0, 1, words[k]);           // REQ with same-cycle ack
    end
    at_neg();
    chk("t2_ready_count", 32'(n_ready), 32'd4);

    // 3: stall at ack time, word held while stalled
    exp_addr.push_back(32'hC);
    for (int k = 0; k < 4; k++) exp_instr.push_back(32'hDEADBEEF);
    drv(32'hC, 0, 0, 0, 32'h0);                     // IDLE launch
    drv(32'hC, 0, 1, 1, 32'hDEADBEEF);              // ack under stall -> HOLD
    drv(32'hC, 0, 1, 0, 32'h0);                     // HOLD
    at_neg();
    chk("t3_hold_mem_req_a", {31'b0, bus.mem_req}, 32'd0);
    drv(32'hC, 0, 1, 0, 32'h0);                     // HOLD
    at_neg();
    chk("t3_hold_mem_req_b", {31'b0, bus.mem_req}, 32'd0);
    drv(32'hC, 0, 0, 0, 32'h0);                     // HOLD, stall dropped -> IDLE
    at_neg();
    chk("t3_hold_mem_req_c", {31'b0, bus.mem_req}, 32'd0);
    chk("t3_ready_count", 32'(n_ready), 32'd8);

    // 4: redirect one cycle after launch; in-flight data must be dropped
    exp_addr.push_back(32'h10);                     // drained read still acks on 0x10
    drv(32'h10, 0, 0, 0, 32'h0);                    // IDLE launch
    at_neg();
    chk("t3_back_to_idle", {31'b0, bus.mem_req}, 32'd0);
    drv(32'h100, 1, 0, 0, 32'h0);                   // REQ + redirect -> DRAIN
    drv(32'h100, 0, 0, 0, 32'h0);                   // DRAIN
    drv(32'h100, 0, 0, 0, 32'h0);                   // DRAIN
    at_neg();
    chk("t4_drain_mem_req", {31'b0, bus.mem_req}, 32'd1);
    chk("t4_drain_addr_stable", bus.mem_addr, 32'h10);
    drv(32'h100, 0, 0, 1, 32'h11111111);            // late ack, discarded
    exp_addr.push_back(32'h100);
    exp_instr.push_back(32'h00000113);
    drv(32'h100, 0, 0, 0, 32'h0);                   // IDLE launch at redirect target
    drv(32'h100, 0, 0, 1, 32'h00000113);
    at_neg();
    chk("t4_ready_count", 32'(n_ready), 32'd9);

    // 5: memory silent for 16 cycles -> sticky timeout, request held
    exp_addr.push_back(32'h104);
    drv(32'h104, 0, 0, 0, 32'h0);                   // IDLE launch
    for (int i = 0; i < 16; i++) begin
      drv(32'h104, 0, 0, 0, 32'h0);
      at_neg();
      chk("t5_err_low_before_timeout", {31'b0, bus.timeout_err}, 32'd0);
      chk("t5_mem_req_held", {31'b0, bus.mem_req}, 32'd1);
    end
    drv(32'h104, 0, 0, 0, 32'h0);
    at_neg();
    chk("t5_err_set", {31'b0, bus.timeout_err}, 32'd1);
    chk("t5_mem_req_after_timeout", {31'b0, bus.mem_req}, 32'd1);
    exp_instr.push_back(32'h00208133);
    drv(32'h104, 0, 0, 1, 32'h00208133);            // late ack completes normally
    drv(32'h200, 0, 0, 0, 32'h0);                   // IDLE launch of 0x200
    at_neg();
    chk("t5_err_sticky", {31'b0, bus.timeout_err}, 32'd1);
    chk("t5_ready_count", 32'(n_ready), 32'd10);

    // 6: reset mid-REQ, stale ack afterwards
    drv(32'h200, 0, 0, 0, 32'h0);                   // REQ waiting
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("t6_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("t6_rst_mem_addr", bus.mem_addr, 32'd0);
    chk("t6_rst_ready", {31'b0, bus.imem_ready}, 32'd0);
    chk("t6_rst_instr", bus.instr_in, 32'd0);
    chk("t6_rst_err", {31'b0, bus.timeout_err}, 32'd0);
    bus.mem_ack   = 1'b1;                           // stale ack for the abandoned read
    bus.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;                                  // IDLE, stale ack still high
    bus.pc = 32'h300;
    exp_addr.push_back(32'h300);
    exp_instr.push_back(32'h00300193);
    drv(32'h300, 0, 0, 0, 32'h0);                   // fresh REQ
    at_neg();
    chk("t6_fresh_addr", bus.mem_addr, 32'h300);
    chk("t6_fresh_req", {31'b0, bus.mem_req}, 32'd1);
    drv(32'h300, 0, 0, 1, 32'h00300193);
    drv(32'h304, 1, 0, 0, 32'h0);                   // IDLE held by redirect
    at_neg();
    chk("t6_ready_count", 32'(n_ready), 32'd11);
    chk("idle_on_redirect", {31'b0, bus.mem_req}, 32'd0);

    repeat (2) @(negedge clk);
    chk("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
